shift_add_mul: RTL and testbench

- Sequential unsigned shift-and-add multiplier for the ALU datapath.
- Sits directly downstream of the 4-bit carry-look-ahead adder slices: instantiates WIDTH/4 of them chained into one WIDTH-bit adder, drives their operands every cycle and consumes their sum and carry-out.
- Presents a start/busy/done handshake to the ALU control and holds the 2*WIDTH-bit product until the next operation.

---
 rtl/shift_add_mul.sv | 159 +++++++++++++++
 tb/tb_shift_add_mul.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/shift_add_mul.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module     : shift_add_mul (with helper cla4_slice)
// Purpose    : Sequential unsigned shift-and-add multiplier. The WIDTH-bit
//              adder is a ripple chain of 4-bit carry-look-ahead slices. Each
//              EXEC cycle adds the multiplicand (or zero) to the upper half of
//              the accumulator, then shifts the full accumulator right by one.
// Ports      : clk    - rising-edge clock
//              reset  - asynchronous active-high reset
//              start  - multiply request, sampled only in IDLE
//              a, b   - multiplicand / multiplier, sampled with start
//              busy   - high during EXEC
//              done   - one-cycle pulse when result becomes valid
//              result - 2*WIDTH-bit product, registered and held
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------

module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Every carry is a flat function of generate/propagate terms and cin.
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign sum  = w_p ^ w_c[3:0];
  assign cout = w_c[4];
endmodule

module shift_add_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);
  localparam int C_SLICES = WIDTH / 4;
  localparam int C_CW     = $clog2(WIDTH + 1);
  localparam logic [C_CW-1:0] C_COUNT_INIT = C_CW'(WIDTH);
  localparam logic [C_CW-1:0] C_COUNT_LAST = C_CW'(1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
      $error("shift_add_mul: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [C_CW-1:0]    r_count;
  logic [2*WIDTH-1:0] r_result;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic [C_SLICES:0]  w_carry;
  logic [2*WIDTH-1:0] w_shifted;

  // Multiplier LSB selects whether the multiplicand is added this step.
  assign w_addend   = r_acc_lo[0] ? r_mcand : '0;
  assign w_carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < C_SLICES; gi++) begin : g_cla
      cla4_slice u_slice (
        .a    (r_acc_hi[4*gi +: 4]),
        .b    (w_addend[4*gi +: 4]),
        .cin  (w_carry[gi]),
        .sum  (w_sum[4*gi +: 4]),
        .cout (w_carry[gi+1])
      );
    end
  endgenerate

  // Top carry-out becomes the new MSB, so no product bit is ever dropped.
  assign w_shifted = {w_carry[C_SLICES], w_sum, r_acc_lo[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_EXEC;
      S_EXEC:  if (r_count == C_COUNT_LAST) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand  <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= a;
            r_acc_hi <= '0;
            r_acc_lo <= b;
            r_count  <= C_COUNT_INIT;
          end
        end
        S_EXEC: begin
          {r_acc_hi, r_acc_lo} <= w_shifted;
          r_count              <= r_count - C_COUNT_LAST;
          if (r_count == C_COUNT_LAST) begin
            r_result <= w_shifted;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state == S_EXEC);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
endmodule

`default_nettype wire

// File: tb/tb_shift_add_mul.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module     : tb_shift_add_mul
// Purpose    : Directed, self-checking bench for shift_add_mul (WIDTH = 8).
//              Expected products are queued when an operation is accepted and
//              popped when the done pulse is observed.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------

module tb_shift_add_mul;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_done_cyc = -1;
  logic [2*W-1:0] sb[$];

  shift_add_mul #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) check("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
  end

  // Drive one request at a negedge; it is accepted at the following posedge.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [2*W-1:0] e;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    e = av * bv;
    sb.push_back(e);
  endtask

  // Called at the negedge just after issue(); counts busy cycles, then checks
  // the done pulse and result. keep_start leaves start high with noise on a/b.
  task automatic finish_op(input string tag, input bit keep_start, input bit noise);
    int n;
    logic [2*W-1:0] e;
    @(negedge clk);
    if (!keep_start) start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < W + 4) begin
      n++;
      if (noise) begin a = 8'd3; b = 8'd3; end
      else begin a = W'($urandom); b = W'($urandom); end
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, n, W);
    check({tag, "_done_high"}, {31'd0, done}, 32'd1);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '1;
    check({tag, "_result"}, {16'd0, result}, {16'd0, e});
    if (last_done_cyc >= 0 && keep_start && !noise)
      check({tag, "_spacing"}, cyc - last_done_cyc, W + 2);
    last_done_cyc = cyc;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", {16'd0, result}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic multiply and done-pulse width.
    issue(8'd13, 8'd11);
    finish_op("m13x11", 1'b0, 1'b0);
    @(negedge clk);
    check("m13x11_done_pulse", {31'd0, done}, 32'd0);
    check("m13x11_hold", {16'd0, result}, 32'h008F);

    issue(8'd255, 8'd255);
    finish_op("m255x255", 1'b0, 1'b0);
    issue(8'd0, 8'd200);
    finish_op("m0x200", 1'b0, 1'b0);
    issue(8'd200, 8'd0);
    finish_op("m200x0", 1'b0, 1'b0);
    issue(8'd1, 8'd1);
    finish_op("m1x1", 1'b0, 1'b0);

    // start held during EXEC and DONE with other operands: must be ignored.
    issue(8'd7, 8'd9);
    finish_op("m7x9_ignore", 1'b1, 1'b1);
    @(negedge clk);
    check("ignore_in_done_busy", {31'd0, busy}, 32'd0);
    check("ignore_in_done_result", {16'd0, result}, 32'd63);
    start = 1'b0;
    @(negedge clk);
    check("ignore_still_idle", {31'd0, busy}, 32'd0);

    // Reset during the 4th EXEC cycle aborts with everything cleared.
    issue(8'd100, 8'd100);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_was_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", {16'd0, result}, 32'd0);
    void'(sb.pop_front());
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_idle_result", {16'd0, result}, 32'd0);
    issue(8'd100, 8'd100);
    finish_op("m100x100", 1'b0, 1'b0);

    // Back-to-back with start held high; one new accept every W+2 cycles.
    last_done_cyc = -1;
    for (int i = 0; i < 6; i++) begin
      issue(W'($urandom), W'($urandom));
      finish_op("b2b", 1'b1, 1'b0);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
